muldiv_unit: RTL

//   Iterative multiply/divide unit beside the ALU in the MIPS150 execute stage.
//   It takes the same A/B operands the ALU sees and implements

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// One shared 2*WIDTH accumulator serves shift-add multiply and restoring divide.
module muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 div_q, div_d, sa_q, sa_d, sb_q, sb_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]     b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, step, prod;
  logic [WIDTH:0]       r, r2, s;
  logic                 ge, a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs, quo, rem;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  // Low half holds multiplier (mul) or dividend->quotient (div); high half the partial sum/remainder.
  always_comb begin
    a_neg = !op[0] && A[WIDTH-1];
    b_neg = !op[0] && B[WIDTH-1];
    a_abs = a_neg ? -A : A;
    b_abs = b_neg ? -B : B;
    step  = acc_q;
    r     = '0;
    r2    = '0;
    s     = '0;
    ge    = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_q) begin
        r    = {step[2*WIDTH-1:WIDTH], step[WIDTH-1]};
        ge   = r >= {1'b0, b_q};
        r2   = ge ? r - {1'b0, b_q} : r;
        step = {r2[WIDTH-1:0], step[WIDTH-2:0], ge};
      end else begin
        s    = {1'b0, step[2*WIDTH-1:WIDTH]} + (step[0] ? {1'b0, b_q} : '0);
        step = {s, step[WIDTH-1:1]};
      end
    end
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = op[1];
          sa_d    = a_neg;
          sb_d    = b_neg;
          b_d     = b_abs;
          acc_d   = {{WIDTH{1'b0}}, a_abs};
        end else begin
          hi_d = mthi ? A : hi_q;
          lo_d = mtlo ? A : lo_q;
        end
      end
      RUN: begin
        acc_d   = step;
        cnt_d   = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1)) ? FIX : RUN;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // Divide by zero leaves |A| as remainder, so re-signing it restores the raw dividend.
        lo_d = !div_q ? prod[WIDTH-1:0] : (b_q == '0) ? '1 : (sa_q ^ sb_q) ? -quo : quo;
        hi_d = !div_q ? prod[2*WIDTH-1:WIDTH] : sa_q ? -rem : rem;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
